// File: rtl/mips_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module      : mips_writeback_unit
// Description : Register-file write-port arbiter for ALU results and load
//               returns, with a collision FIFO and a pending-write hazard query.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_writeback_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  alu_valid,
   output logic                  alu_ready,
   input  logic [4:0]            alu_dst,
   input  logic [DATA_WIDTH-1:0] alu_data,
   input  logic                  load_issue,
   output logic                  load_issue_ready,
   input  logic [4:0]            load_dst,
   input  logic                  mem_rvalid,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic [4:0]            query_addr_1,
   input  logic [4:0]            query_addr_2,
   input  logic [4:0]            query_addr_dst,
   output logic                  hazard,
   output logic                  rf_write_enable,
   output logic [4:0]            rf_dst_addr,
   output logic [DATA_WIDTH-1:0] rf_write_data
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] C_FIFO_FULL = CNT_W'(FIFO_DEPTH);
   localparam logic [PTR_W-1:0] C_PTR_ONE   = PTR_W'(1);
   localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);

   typedef enum logic [0:0] {
      S_IDLE      = 1'b0,
      S_WAIT_LOAD = 1'b1
   } state_t;

   state_t                r_state;
   logic [4:0]            r_load_dst;
   logic [4:0]            r_fifo_dst  [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [CNT_W-1:0]      r_count;

   logic                  w_fifo_empty;
   logic                  w_fifo_full;
   logic                  w_alu_accept;
   logic                  w_load_return;
   logic                  w_sel_valid;
   logic [4:0]            w_sel_dst;
   logic [DATA_WIDTH-1:0] w_sel_data;
   logic                  w_push;
   logic                  w_pop;
   logic [31:0]           w_pend;
   logic [PTR_W-1:0]      w_off;

   assign w_fifo_empty     = (r_count == '0);
   assign w_fifo_full      = (r_count == C_FIFO_FULL);
   assign alu_ready        = !reset && !w_fifo_full;
   assign load_issue_ready = !reset && (r_state == S_IDLE);
   assign w_alu_accept     = alu_valid && alu_ready;
   assign w_load_return    = (r_state == S_WAIT_LOAD) && mem_rvalid;

   // Load return beats queued ALU results, which beat a fresh ALU result;
   // a fresh result only bypasses the FIFO when nothing older is queued.
   always_comb begin
      w_sel_valid = 1'b0;
      w_sel_dst   = '0;
      w_sel_data  = '0;
      w_pop       = 1'b0;
      w_push      = 1'b0;
      if (w_load_return) begin
         w_sel_valid = 1'b1;
         w_sel_dst   = r_load_dst;
         w_sel_data  = mem_rdata;
         w_push      = w_alu_accept;
      end else if (!w_fifo_empty) begin
         w_sel_valid = 1'b1;
         w_sel_dst   = r_fifo_dst[r_rd_ptr];
         w_sel_data  = r_fifo_data[r_rd_ptr];
         w_pop       = 1'b1;
         w_push      = w_alu_accept;
      end else if (w_alu_accept) begin
         w_sel_valid = 1'b1;
         w_sel_dst   = alu_dst;
         w_sel_data  = alu_data;
      end
   end

   // One bit per architectural register that still has a write in flight.
   always_comb begin
      w_pend = '0;
      w_off  = '0;
      if (r_state == S_WAIT_LOAD) begin
         w_pend[r_load_dst] = 1'b1;
      end
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         w_off = PTR_W'(i) - r_rd_ptr;
         if ({1'b0, w_off} < r_count) begin
            w_pend[r_fifo_dst[i]] = 1'b1;
         end
      end
      if (rf_write_enable) begin
         w_pend[rf_dst_addr] = 1'b1;
      end
      w_pend[0] = 1'b0;
   end

   assign hazard = w_pend[query_addr_1] | w_pend[query_addr_2] | w_pend[query_addr_dst];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state         <= S_IDLE;
         r_load_dst      <= '0;
         r_rd_ptr        <= '0;
         r_wr_ptr        <= '0;
         r_count         <= '0;
         rf_write_enable <= 1'b0;
         rf_dst_addr     <= '0;
         rf_write_data   <= '0;
      end else begin
         // $0 writes are consumed but never reach the register file.
         rf_write_enable <= w_sel_valid && (w_sel_dst != 5'd0);
         if (w_sel_valid) begin
            rf_dst_addr   <= w_sel_dst;
            rf_write_data <= w_sel_data;
         end

         case (r_state)
            S_IDLE: begin
               if (load_issue) begin
                  r_load_dst <= load_dst;
                  r_state    <= S_WAIT_LOAD;
               end
            end
            S_WAIT_LOAD: begin
               if (mem_rvalid) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase

         if (w_push) begin
            r_fifo_dst[r_wr_ptr]  <= alu_dst;
            r_fifo_data[r_wr_ptr] <= alu_data;
            r_wr_ptr              <= r_wr_ptr + C_PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + C_CNT_ONE;
            2'b01:   r_count <= r_count - C_CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mips_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_writeback_unit
// Description : Directed self-checking bench for mips_writeback_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_writeback_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        alu_valid;
   logic        alu_ready;
   logic [4:0]  alu_dst;
   logic [31:0] alu_data;
   logic        load_issue;
   logic        load_issue_ready;
   logic [4:0]  load_dst;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic [4:0]  query_addr_1;
   logic [4:0]  query_addr_2;
   logic [4:0]  query_addr_dst;
   logic        hazard;
   logic        rf_write_enable;
   logic [4:0]  rf_dst_addr;
   logic [31:0] rf_write_data;

   int tests = 0;
   int fails = 0;

   mips_writeback_unit #(.DATA_WIDTH(32), .FIFO_DEPTH(2)) dut (
      .clk              (clk),
      .reset            (reset),
      .alu_valid        (alu_valid),
      .alu_ready        (alu_ready),
      .alu_dst          (alu_dst),
      .alu_data         (alu_data),
      .load_issue       (load_issue),
      .load_issue_ready (load_issue_ready),
      .load_dst         (load_dst),
      .mem_rvalid       (mem_rvalid),
      .mem_rdata        (mem_rdata),
      .query_addr_1     (query_addr_1),
      .query_addr_2     (query_addr_2),
      .query_addr_dst   (query_addr_dst),
      .hazard           (hazard),
      .rf_write_enable  (rf_write_enable),
      .rf_dst_addr      (rf_dst_addr),
      .rf_write_data    (rf_write_data)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests++;
      assert (observed === expected)
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic chk_rf(input string tag, input logic we, input logic [4:0] dst, input logic [31:0] data);
      chk({tag, "_we"},   {31'd0, rf_write_enable}, {31'd0, we});
      chk({tag, "_dst"},  {27'd0, rf_dst_addr},     {27'd0, dst});
      chk({tag, "_data"}, rf_write_data,            data);
   endtask

   task automatic alu(input logic v, input logic [4:0] d, input logic [31:0] x);
      alu_valid = v;
      alu_dst   = d;
      alu_data  = x;
   endtask

   initial begin
      reset = 1'b1;
      alu(1'b0, 5'd0, 32'h0);
      load_issue = 1'b0; load_dst = 5'd0;
      mem_rvalid = 1'b0; mem_rdata = 32'h0;
      query_addr_1 = 5'd0; query_addr_2 = 5'd0; query_addr_dst = 5'd0;

      // Reset state
      tick(); tick();
      chk_rf("reset", 1'b0, 5'd0, 32'h0);
      chk("reset_alu_ready", {31'd0, alu_ready}, 32'd0);
      chk("reset_lir", {31'd0, load_issue_ready}, 32'd0);
      reset = 1'b0;
      query_addr_1 = 5'd5; query_addr_2 = 5'd8; query_addr_dst = 5'd31;
      #1;
      chk("idle_alu_ready", {31'd0, alu_ready}, 32'd1);
      chk("idle_lir", {31'd0, load_issue_ready}, 32'd1);
      chk("idle_hazard", {31'd0, hazard}, 32'd0);
      query_addr_2 = 5'd0; query_addr_dst = 5'd0;

      // Single ALU write
      alu(1'b1, 5'd5, 32'hDEADBEEF);
      tick();
      alu(1'b0, 5'd0, 32'h0);
      #1;
      chk_rf("alu1", 1'b1, 5'd5, 32'hDEADBEEF);
      chk("alu1_hazard", {31'd0, hazard}, 32'd1);
      tick();
      chk("alu1_we_off", {31'd0, rf_write_enable}, 32'd0);
      chk("alu1_hazard_off", {31'd0, hazard}, 32'd0);

      // Load dst 8 with response in the 4th waiting cycle, stray issue ignored
      load_issue = 1'b1; load_dst = 5'd8;
      tick();
      query_addr_1 = 5'd8;
      for (int c = 0; c < 4; c++) begin
         load_issue = (c == 1);
         load_dst   = (c == 1) ? 5'd9 : 5'd0;
         mem_rvalid = (c == 3);
         mem_rdata  = (c == 3) ? 32'h12345678 : 32'h0;
         #1;
         chk($sformatf("ld_wait%0d_lir", c), {31'd0, load_issue_ready}, 32'd0);
         chk($sformatf("ld_wait%0d_hazard", c), {31'd0, hazard}, 32'd1);
         tick();
      end
      load_issue = 1'b0; mem_rvalid = 1'b0;
      #1;
      chk_rf("ld1", 1'b1, 5'd8, 32'h12345678);
      chk("ld1_lir", {31'd0, load_issue_ready}, 32'd1);
      chk("ld1_hazard_rf", {31'd0, hazard}, 32'd1);
      tick();
      query_addr_2 = 5'd9;
      #1;
      chk("ld1_we_off", {31'd0, rf_write_enable}, 32'd0);
      chk("ld1_hazard_off", {31'd0, hazard}, 32'd0);
      chk("ld1_stray_ignored_lir", {31'd0, load_issue_ready}, 32'd1);
      query_addr_1 = 5'd0; query_addr_2 = 5'd0;

      // Collision: load return with ALU, then another ALU
      load_issue = 1'b1; load_dst = 5'd8;
      tick();
      load_issue = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'hAA;
      alu(1'b1, 5'd3, 32'h11);
      #1;
      chk("col_ready0", {31'd0, alu_ready}, 32'd1);
      tick();
      chk_rf("col_w0", 1'b1, 5'd8, 32'hAA);
      mem_rvalid = 1'b0;
      alu(1'b1, 5'd4, 32'h22);
      query_addr_2 = 5'd3;
      #1;
      chk("col_ready1", {31'd0, alu_ready}, 32'd1);
      chk("col_hazard_fifo", {31'd0, hazard}, 32'd1);
      tick();
      chk_rf("col_w1", 1'b1, 5'd3, 32'h11);
      alu(1'b0, 5'd0, 32'h0);
      query_addr_2 = 5'd0;
      tick();
      chk_rf("col_w2", 1'b1, 5'd4, 32'h22);
      tick();
      chk("col_we_off", {31'd0, rf_write_enable}, 32'd0);

      // FIFO fill under repeated load returns
      load_issue = 1'b1; load_dst = 5'd10;
      tick();
      load_issue = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'hB1;
      alu(1'b1, 5'd11, 32'h111);
      tick();
      chk_rf("full_wB", 1'b1, 5'd10, 32'hB1);
      mem_rvalid = 1'b0;
      load_issue = 1'b1; load_dst = 5'd12;
      alu(1'b1, 5'd13, 32'h131);
      #1;
      chk("full_lirC", {31'd0, load_issue_ready}, 32'd1);
      chk("full_readyC", {31'd0, alu_ready}, 32'd1);
      tick();
      chk_rf("full_wC", 1'b1, 5'd11, 32'h111);
      load_issue = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'hC2;
      alu(1'b1, 5'd14, 32'h141);
      tick();
      chk_rf("full_wD", 1'b1, 5'd12, 32'hC2);
      mem_rvalid = 1'b0;
      alu(1'b1, 5'd15, 32'h151);
      query_addr_dst = 5'd14;
      #1;
      chk("full_readyE", {31'd0, alu_ready}, 32'd0);
      chk("full_hazardE", {31'd0, hazard}, 32'd1);
      tick();
      chk_rf("full_wE", 1'b1, 5'd13, 32'h131);
      query_addr_dst = 5'd0;
      #1;
      chk("full_readyF", {31'd0, alu_ready}, 32'd1);
      tick();
      chk_rf("full_wF", 1'b1, 5'd14, 32'h141);
      alu(1'b0, 5'd0, 32'h0);
      tick();
      chk_rf("full_wG", 1'b1, 5'd15, 32'h151);
      tick();
      chk("full_we_off", {31'd0, rf_write_enable}, 32'd0);

      // $0 suppression
      alu(1'b1, 5'd0, 32'h77);
      #1;
      chk("z_hazard_pre", {31'd0, hazard}, 32'd0);
      tick();
      alu(1'b0, 5'd0, 32'h0);
      #1;
      chk_rf("z_alu", 1'b0, 5'd0, 32'h77);
      chk("z_hazard_alu", {31'd0, hazard}, 32'd0);
      load_issue = 1'b1; load_dst = 5'd0;
      tick();
      load_issue = 1'b0;
      #1;
      chk("z_ld_lir", {31'd0, load_issue_ready}, 32'd0);
      chk("z_ld_hazard", {31'd0, hazard}, 32'd0);
      mem_rvalid = 1'b1; mem_rdata = 32'h99;
      tick();
      mem_rvalid = 1'b0;
      #1;
      chk_rf("z_ld", 1'b0, 5'd0, 32'h99);
      chk("z_ld_idle", {31'd0, load_issue_ready}, 32'd1);

      // Reset during WAIT_LOAD, late response ignored
      load_issue = 1'b1; load_dst = 5'd6;
      tick();
      load_issue = 1'b0;
      query_addr_1 = 5'd6;
      #1;
      chk("rst_wait_hazard", {31'd0, hazard}, 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      chk("rst_lir", {31'd0, load_issue_ready}, 32'd1);
      chk("rst_hazard", {31'd0, hazard}, 32'd0);
      chk_rf("rst_rf", 1'b0, 5'd0, 32'h0);
      mem_rvalid = 1'b1; mem_rdata = 32'h55;
      tick();
      mem_rvalid = 1'b0;
      chk_rf("rst_late", 1'b0, 5'd0, 32'h0);
      query_addr_1 = 5'd0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mips_writeback_unit.md
Name: mips_writeback_unit

Overview:
- Drives the register file write port (write_enable, dst_addr, write_data) from two producers: single-cycle ALU results and variable-latency memory load responses.
- Buffers ALU results that collide with a load return in a small FIFO.
- Tracks one outstanding load with a two-state FSM.
- Exposes a combinational hazard query so decode can stall on registers with pending writes.

Parameters:
- DATA_WIDTH, 32, width of result data and register file write data.
- FIFO_DEPTH, 2, number of ALU result entries held during load-return collisions; power of two, minimum 2.

Ports:
- clk  input  1  clock.
- reset  input  1  reset, synchronous, active-high.
- alu_valid  input  1  ALU result offered this cycle.
- alu_ready  output  1  ALU result accepted when alu_valid && alu_ready.
- alu_dst  input  5  ALU destination register.
- alu_data  input  DATA_WIDTH  ALU result.
- load_issue  input  1  memory stage issues a load this cycle.
- load_issue_ready  output  1  a new load may issue.
- load_dst  input  5  load destination register, sampled on issue.
- mem_rvalid  input  1  load response valid, one-cycle pulse.
- mem_rdata  input  DATA_WIDTH  load response data.
- query_addr_1  input  5  decode source register 1.
- query_addr_2  input  5  decode source register 2.
- query_addr_dst  input  5  decode destination register (WAW check).
- hazard  output  1  any queried register has a pending write.
- rf_write_enable  output  1  register file write enable, registered.
- rf_dst_addr  output  5  register file write address, registered.
- rf_write_data  output  DATA_WIDTH  register file write data, registered.

Behaviour:
- Reset (sync, takes priority over all inputs):
  - rf_write_enable=0, rf_dst_addr=0, rf_write_data=0.
  - FIFO emptied; FSM set to IDLE; pending load dst cleared.
  - alu_ready=0 and load_issue_ready=0 while reset is high.
  - Outputs take reset values at the first edge with reset high. Any in-flight load is discarded; a mem_rvalid arriving after reset with FSM in IDLE is ignored.
- FSM:
  - IDLE: load_issue_ready=1. load_issue latches load_dst -> WAIT_LOAD.
  - WAIT_LOAD: load_issue_ready=0. load_issue is ignored. mem_rvalid -> IDLE at the same edge.
  - A new load can issue no earlier than the cycle after the response.
- Write source selection each cycle, highest priority first:
  - (1) mem_rvalid in WAIT_LOAD: pending load dst and mem_rdata.
  - (2) FIFO head, if non-empty: pop.
  - (3) accepted ALU result, bypassing the FIFO (FIFO empty only).
- The selected source is registered into rf_* at the next edge. Latency is 1 cycle from the input handshake to rf_write_enable high. No source selected -> rf_write_enable=0 next cycle.
- Accepted ALU result not selected (load return, or FIFO non-empty) is pushed to the FIFO tail.
- Ordering: ALU results are written in acceptance order.
- alu_ready = FIFO not full. Combinational; does not depend on alu_valid or mem_rvalid.
  - A full FIFO popping this cycle does not assert alu_ready.
  - With FIFO_DEPTH=2, at most 1 result is pushed and 1 popped per cycle, so there is no overflow.
- Register $0:
  - Any write with dst 0 (load or ALU) is consumed normally, but rf_write_enable stays 0 for that cycle.
  - rf_dst_addr and rf_write_data still update.
- Hazard, combinational. For each query address q, busy(q) is 1 when q!=0 and any of:
  - FSM is WAIT_LOAD and pending dst==q;
  - any valid FIFO entry has dst==q;
  - rf_write_enable is high and rf_dst_addr==q.
  - hazard = busy(query_addr_1) | busy(query_addr_2) | busy(query_addr_dst).
- The register file reads the written value from the cycle after rf_write_enable falls for that entry, so busy drops exactly when data is readable.

Test Plan:
- Reset then idle: all rf_* = 0; after reset deasserts, alu_ready=1, load_issue_ready=1, hazard=0 for any query.
- Single ALU write alu_valid, dst=5, data=0xDEADBEEF -> next cycle rf_write_enable=1, rf_dst_addr=5, rf_write_data=0xDEADBEEF; hazard=1 for query_addr_1=5 during that cycle only.
- Load dst=8, issued, response 0x12345678 after 4 cycles:
  - load_issue_ready=0 for 4 cycles; hazard=1 for query 8 throughout.
  - rf write of 8/0x12345678 one cycle after mem_rvalid.
  - A second load_issue during the wait is ignored.
- Collision: mem_rvalid (dst 8, 0xAA) together with ALU dst 3/0x11, then ALU dst 4/0x22 next cycle:
  - rf writes 8/0xAA, 3/0x11, 4/0x22 on consecutive cycles.
  - alu_ready stays 1 (FIFO peaks at 1).
- FIFO full: back-to-back ALU writes during repeated load returns -> alu_ready=0 when 2 entries are held; no ALU result is lost or reordered.
- $0 suppression: ALU dst=0 and load dst=0 -> rf_write_enable never high; hazard=0 for query 0; FSM still returns to IDLE. Reset mid WAIT_LOAD -> IDLE, a late mem_rvalid produces no write.
